// File: rtl/vga_pattern_gen_if.sv
// vga_pattern_gen_if: pixel stream bundle between the pattern generator and its sink
//   master (generator): takes enable/mode/ready, drives VGA_X/VGA_Y/VGA_COLOR/plot/frame_done/busy
//   slave (sink/controller): the mirror image
interface vga_pattern_gen_if #(
    parameter int X_W     = 8,
    parameter int Y_W     = 7,
    parameter int COLOR_W = 3
);
    logic               enable;
    logic [1:0]         mode;
    logic               ready;
    logic [X_W-1:0]     VGA_X;
    logic [Y_W-1:0]     VGA_Y;
    logic [COLOR_W-1:0] VGA_COLOR;
    logic               plot;
    logic               frame_done;
    logic               busy;
    modport master (
        input  enable, mode, ready,
        output VGA_X, VGA_Y, VGA_COLOR, plot, frame_done, busy
    );
    modport slave (
        output enable, mode, ready,
        input  VGA_X, VGA_Y, VGA_COLOR, plot, frame_done, busy
    );
endinterface

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: frame-by-frame test pattern generator (solid, bars, checkerboard)
//   CLOCK_50 : clock, rising edge
//   reset    : synchronous active-high reset
//   bus      : master side of vga_pattern_gen_if (enable/mode/ready in, pixel stream out)
module vga_pattern_gen #(
    parameter int COLS        = 160,
    parameter int ROWS        = 120,
    parameter int X_W         = 8,
    parameter int Y_W         = 7,
    parameter int COLOR_W     = 3,
    parameter int BAR_SHIFT   = 4,
    parameter int HOLD_CYCLES = 0
) (
    input logic             CLOCK_50,
    input logic             reset,
    vga_pattern_gen_if.master bus
);
    localparam int HW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [COLOR_W-1:0] CMAX = '1;
    typedef enum logic [1:0] {IDLE, DRAW, HOLD} state_t;
    state_t             state_q, state_d;
    logic [X_W-1:0]     x_q, x_d, xs;
    logic [Y_W-1:0]     y_q, y_d, ys;
    logic [COLOR_W-1:0] base_q, base_d, color_q, color_d;
    logic [1:0]         mode_q, mode_d;
    logic [HW-1:0]      hold_q, hold_d;
    logic               done_q, done_d, decide;
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            base_q  <= '0;
            mode_q  <= '0;
            hold_q  <= '0;
            color_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            base_q  <= base_d;
            mode_q  <= mode_d;
            hold_q  <= hold_d;
            color_q <= color_d;
            done_q  <= done_d;
        end
    end
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        base_d  = base_q;
        mode_d  = mode_q;
        hold_d  = hold_q;
        done_d  = 1'b0;
        decide  = 1'b0;
        case (state_q)
            IDLE: decide = 1'b1;
            DRAW: if (bus.ready) begin
                if (x_q == X_W'(COLS - 1)) begin
                    x_d = '0;
                    if (y_q == Y_W'(ROWS - 1)) begin
                        y_d    = '0;
                        done_d = 1'b1;
                        // after the first frame the base cycles 1..max, skipping 0
                        base_d = base_q == CMAX ? COLOR_W'(1) : base_q + 1'b1;
                        if (HOLD_CYCLES > 0) state_d = HOLD;
                        else decide = 1'b1;
                    end else begin
                        y_d = y_q + 1'b1;
                    end
                end else begin
                    x_d = x_q + 1'b1;
                end
            end
            HOLD: if (hold_q == HW'(HOLD_CYCLES - 1)) begin
                hold_d = '0;
                decide = 1'b1;
            end else begin
                hold_d = hold_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
        // frame start: mode is only ever sampled here, so mid-frame changes wait
        if (decide) begin
            state_d = bus.enable ? DRAW : IDLE;
            mode_d  = bus.enable ? bus.mode : mode_q;
        end
        // colour is computed from next-state values so it registers alongside x/y
        xs = x_d >> BAR_SHIFT;
        ys = y_d >> BAR_SHIFT;
        color_d = mode_d == 2'd0 ? base_d :
                  mode_d == 2'd1 ? base_d + COLOR_W'(xs) :
                  mode_d == 2'd2 ? base_d + COLOR_W'(ys) :
                  (xs[0] ^ ys[0]) ? ~base_d : base_d;
    end
    assign bus.VGA_X      = x_q;
    assign bus.VGA_Y      = y_q;
    assign bus.VGA_COLOR  = color_q;
    assign bus.plot       = state_q == DRAW;
    assign bus.frame_done = done_q;
    assign bus.busy       = state_q != IDLE;
endmodule

// File: doc/vga_pattern_gen.md
VGA_PATTERN_GEN -- requirements
Module: vga_pattern_gen

Interface
REQ-001 SHALL have parameter COLS, default 160, meaning the pixel columns per frame.
REQ-002 SHALL have parameter ROWS, default 120, meaning the pixel rows per frame.
REQ-003 SHALL have parameter X_W, default 8, meaning the column coordinate width; it SHALL satisfy 2**X_W >= COLS.
REQ-004 SHALL have parameter Y_W, default 7, meaning the row coordinate width; it SHALL satisfy 2**Y_W >= ROWS.
REQ-005 SHALL have parameter COLOR_W, default 3, meaning the pixel colour width.
REQ-006 SHALL have parameter BAR_SHIFT, default 4, meaning log2 of the bar/tile size in pixels.
REQ-007 SHALL have parameter HOLD_CYCLES, default 0, meaning the idle cycles between frames; 0 means no hold.
REQ-008 SHALL have port CLOCK_50, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-009 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-010 SHALL have port enable, input, 1 bit: request to draw frames.
REQ-011 SHALL have port mode, input, 2 bits: pattern select, sampled at each frame start.
REQ-012 SHALL have port ready, input, 1 bit: the downstream sink accepts the current pixel.
REQ-013 SHALL have port VGA_X, output, X_W bits: pixel column.
REQ-014 SHALL have port VGA_Y, output, Y_W bits: pixel row.
REQ-015 SHALL have port VGA_COLOR, output, COLOR_W bits: pixel colour.
REQ-016 SHALL have port plot, output, 1 bit: the current pixel is valid.
REQ-017 SHALL have port frame_done, output, 1 bit: one-cycle pulse when the last pixel of a frame is accepted.
REQ-018 SHALL have port busy, output, 1 bit: high in DRAW or HOLD.

Function
REQ-019 SHALL implement FSM states IDLE, DRAW and HOLD; all outputs are driven from registered state only, with no combinational input-to-output path.
REQ-020 IDLE: plot=0; when enable=1, the next state is DRAW with x=0, y=0, and mode latched into mode_q.
REQ-021 DRAW: plot=1; a pixel is accepted only on a cycle with plot=1 and ready=1; with ready=0, VGA_X, VGA_Y and VGA_COLOR SHALL hold unchanged.
REQ-022 On acceptance, x SHALL increment; at x=COLS-1, x wraps to 0 and y increments; at x=COLS-1 and y=ROWS-1, the frame ends.
REQ-023 At frame end: frame_done=1 for exactly the following cycle, base colour advances, x=0, y=0, and the state goes to HOLD if HOLD_CYCLES>0, else to the frame-start decision.
REQ-024 HOLD: plot=0; the block counts HOLD_CYCLES cycles, then takes the frame-start decision.
REQ-025 Frame-start decision: if enable=1, go to DRAW and re-latch mode; otherwise go to IDLE.
REQ-026 Deasserting enable during DRAW SHALL NOT abort the frame; the frame completes first.
REQ-027 Base colour advance: base+1; when base = 2**COLOR_W-1, the next value is 1 (0 is never reused after the first frame).
REQ-028 mode_q=0 (solid): colour = base.
REQ-029 mode_q=1 (vertical bars): colour = (base + (x>>BAR_SHIFT)) mod 2**COLOR_W.
REQ-030 mode_q=2 (horizontal bars): colour = (base + (y>>BAR_SHIFT)) mod 2**COLOR_W.
REQ-031 mode_q=3 (checkerboard): colour = base if ((x>>BAR_SHIFT) XOR (y>>BAR_SHIFT)) bit0 = 0, else bitwise NOT base.
REQ-032 VGA_COLOR SHALL always correspond to the VGA_X/VGA_Y presented in the same cycle.
REQ-033 A mode change mid-frame SHALL have no effect until the next frame start.

Reset
REQ-034 When reset=1 at a clock edge, the block SHALL enter IDLE with x=0, y=0, base=0, mode_q=0, hold counter=0, plot=0, frame_done=0 and busy=0, overriding all other inputs, including mid-frame and during HOLD.
REQ-035 After reset, the first frame SHALL be drawn with base=0.

Verification
REQ-036 Defaults, enable=1, ready=1, mode=0: first plot at (0,0) with colour 0; frame_done pulses after exactly 19200 accepted pixels; the second frame has colour 1; the frame after colour 7 has colour 1.
REQ-037 ready toggling 1,0,0,1 during DRAW: VGA_X/VGA_Y/VGA_COLOR stay stable while ready=0; pixel count per frame is still 19200 with no skips or duplicates.
REQ-038 mode=3, base=2: at (0,0) colour=2; at (16,0) colour=5; at (16,16) colour=2; mode=1 at (32,0) colour=4.
REQ-039 HOLD_CYCLES=5: frame_done is followed by exactly 5 cycles with plot=0 and busy=1 before the next (0,0) plot.
REQ-040 enable dropped mid-frame: the frame completes, frame_done pulses, then IDLE with plot=0 and busy=0; re-enable starts at (0,0) with the advanced base.
REQ-041 reset asserted at (57,33) of frame 3: the next cycle has plot=0 and busy=0; on re-enable, drawing starts at (0,0) with colour 0.
